expr_checker_arb: RTL
=====================

// Module: expr_checker_arb
// PURPOSE
//   Shares one ASCII expression checker between two character sources (src0/src1).
//   Grants the checker to one source for a whole expression (locked until TERM), round-robin between expressions.
//   Reports per expression: well-formed flag, source id, length. Sits between the character front-ends and the status/log path.
// PARAMETERS
//   MAX_LEN  15     saturation value of res_len
//   LEN_W    4      width of res_len; must hold MAX_LEN
//   TIMEOUT  16     idle cycles of owner (valid low) before abort; >=1
//   TERM     8'h3B  expression terminator character (';')
// PORTS
//   clk        in   1      system clock, rising edge
//   clr        in   1      reset, asynchronous, active-high
//   s0_valid   in   1      src0 character valid
//   s0_char    in   8      src0 ASCII character
//   s0_ready   out  1      src0 character accepted when s0_valid&s0_ready
//   s1_valid   in   1      src1 character valid
//   s1_char    in   8      src1 ASCII character
//   s1_ready   out  1      src1 character accepted when s1_valid&s1_ready
//   busy       out  1      checker owned by a source
//   res_valid  out  1      one-cycle result pulse
//   res_ok     out  1      expression well-formed (valid with res_valid)
//   res_abort  out  1      expression ended by timeout (valid with res_valid)
//   res_src    out  1      owner of reported expression
//   res_len    out  LEN_W  chars accepted excl. TERM, saturating at MAX_LEN
// BEHAVIOUR
//   Reset: all outputs 0; arbiter IDLE; checker START; len 0; timer 0; last_grant=1 (src0 wins first tie).
//   Arbiter FSM IDLE/OWN. All registered; ready is a function of state/owner only (no valid->ready comb path).
//   IDLE: both readys 0. If any valid: owner <= requester (tie -> !last_grant), go OWN next cycle.
//   OWN: owner ready=1, other ready=0 (its valid/char held, ignored). busy=1.
//     Each accepted non-TERM char steps checker, len <= min(len+1, MAX_LEN), timer <= 0.
//     Owner valid low: timer+1; timer reaching TIMEOUT -> abort.
//     Accepted TERM at cycle N: res_valid=1 at N+1 with res_ok=(checker==DIGIT), res_abort=0, res_src=owner, res_len=len;
//       state IDLE at N+1, last_grant<=owner; earliest next ready at N+2.
//     Abort: res_valid pulse, res_ok=0, res_abort=1, same return to IDLE; partial chars discarded.
//   Checker FSM (operands are single digits):
//     START: '0'-'9' -> DIGIT; else -> ERR.
//     DIGIT: '+','-','*','/' -> OP; digit or other -> ERR.
//     OP:    digit -> DIGIT; else -> ERR.
//     ERR:   sticky until expression end.
//     Checker and len cleared to START/0 on entering IDLE.
//   Boundaries: empty expression (TERM only) -> res_ok=0, len=0. Chars past MAX_LEN still checked; len holds.
//     Non-owner request during OWN waits; serviced next IDLE. Same source may win back-to-back only if other idle.
//     res_* fields hold last value between pulses; only res_valid pulses.
//     clr mid-expression: immediate return to reset state; no result pulse for the cut expression.
// STRUCTURE
//   expr_pkg: TERM default, ASCII range constants ('0','9','+','-','*','/'), checker state enum
//     {START,DIGIT,OP,ERR}, arbiter state enum {IDLE,OWN}.
//   Sub-module expr_fsm: checker FSM; inputs clk, clr, step, ch, restart; output state.
//   Top: arbiter FSM, owner/last_grant regs, len counter, timeout timer, result regs, char mux.
// TESTING
//   src0 sends "1+2+3;" alone -> grant, one char/cycle, res_valid 1 cycle after ';': ok=1, src=0, len=5.
//   Both valid from reset, src0 "1+2;", src1 "4*5;" -> src0 served first, src1 ready only after; results src0 len3 ok, then src1 len3 ok.
//   src0 "12+3;" and src0 "1+;" -> both res_ok=0, len=4 and len=2.
//   src1 sends "7+" then drops valid 16 cycles -> res_valid with abort=1, ok=0, src=1, len=2; IDLE after.
//   src0 sends 20-char valid expression "1+1+...+1;" -> res_ok=1, res_len=15; also ";" alone -> ok=0, len=0.
//   clr pulsed (5 ns) mid "1+2" -> outputs 0, no result pulse; subsequent "3;" from src0 -> ok=1, len=1.

Source files
------------

// File: rtl/expr_pkg.sv
// Shared constants and state types for the two-source ASCII expression checker.
package expr_pkg;

  localparam logic [7:0] TERM_DEF = 8'h3B;  // ';'
  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_9     = 8'h39;
  localparam logic [7:0] CH_ADD   = 8'h2B;
  localparam logic [7:0] CH_SUB   = 8'h2D;
  localparam logic [7:0] CH_MUL   = 8'h2A;
  localparam logic [7:0] CH_DIV   = 8'h2F;

  typedef enum logic [1:0] {START, DIGIT, OP, ERR} chk_state_t;
  typedef enum logic       {IDLE, OWN}             arb_state_t;

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= CH_0) && (c <= CH_9);
  endfunction

  function automatic logic is_op(input logic [7:0] c);
    return (c == CH_ADD) || (c == CH_SUB) || (c == CH_MUL) || (c == CH_DIV);
  endfunction

endpackage

// File: rtl/expr_checker_arb_if.sv
// Character-source handshakes and result bus of the shared expression checker.
interface expr_checker_arb_if #(parameter int LEN_W = 4);
  logic             s0_valid;
  logic [7:0]       s0_char;
  logic             s0_ready;
  logic             s1_valid;
  logic [7:0]       s1_char;
  logic             s1_ready;
  logic             busy;
  logic             res_valid;
  logic             res_ok;
  logic             res_abort;
  logic             res_src;
  logic [LEN_W-1:0] res_len;

  modport master (
    output s0_valid, s0_char, s1_valid, s1_char,
    input  s0_ready, s1_ready, busy, res_valid, res_ok, res_abort, res_src, res_len
  );

  modport slave (
    input  s0_valid, s0_char, s1_valid, s1_char,
    output s0_ready, s1_ready, busy, res_valid, res_ok, res_abort, res_src, res_len
  );
endinterface

// File: rtl/expr_fsm.sv
// Syntax checker for "digit (op digit)*" expressions, one character per step.
module expr_fsm
  import expr_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic       step,
  input  logic [7:0] ch,
  input  logic       restart,
  output chk_state_t state
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= START;
    end else if (restart) begin
      state <= START;
    end else if (step) begin
      unique case (state)
        START: state <= is_digit(ch) ? DIGIT : ERR;
        DIGIT: state <= is_op(ch)    ? OP    : ERR;
        OP:    state <= is_digit(ch) ? DIGIT : ERR;
        ERR:   state <= ERR;
      endcase
    end
  end

endmodule

// File: rtl/expr_checker_arb.sv
// Two-source arbiter around one expression checker: an owner keeps the checker
// for a whole expression, ownership alternates on ties, one result per expression.
module expr_checker_arb
  import expr_pkg::*;
#(
  parameter int         MAX_LEN = 15,
  parameter int         LEN_W   = 4,
  parameter int         TIMEOUT = 16,
  parameter logic [7:0] TERM    = TERM_DEF
)(
  input  logic               clk,
  input  logic               clr,
  expr_checker_arb_if.slave  bus
);

  localparam int TW = $clog2(TIMEOUT + 1);

  arb_state_t       state;
  chk_state_t       chk;
  logic             owner;
  logic             last_grant;
  logic [LEN_W-1:0] len;
  logic [TW-1:0]    timer;

  logic       cur_valid;
  logic [7:0] cur_char;
  logic       accept;
  logic       is_term;
  logic       step;
  logic       timeout_hit;
  logic       restart;

  always_comb begin
    cur_valid = owner ? bus.s1_valid : bus.s0_valid;
    cur_char  = owner ? bus.s1_char  : bus.s0_char;
  end

  assign accept      = (state == OWN) && cur_valid;
  assign is_term     = (cur_char == TERM);
  assign step        = accept && !is_term;
  assign timeout_hit = (state == OWN) && !cur_valid && (timer == TW'(TIMEOUT - 1));
  assign restart     = (accept && is_term) || timeout_hit;

  // Readies decode registered state only, so no valid->ready combinational path.
  assign bus.s0_ready = (state == OWN) && !owner;
  assign bus.s1_ready = (state == OWN) &&  owner;
  assign bus.busy     = (state == OWN);

  expr_fsm u_fsm (
    .clk     (clk),
    .clr     (clr),
    .step    (step),
    .ch      (cur_char),
    .restart (restart),
    .state   (chk)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state         <= IDLE;
      owner         <= 1'b0;
      last_grant    <= 1'b1;
      len           <= '0;
      timer         <= '0;
      bus.res_valid <= 1'b0;
      bus.res_ok    <= 1'b0;
      bus.res_abort <= 1'b0;
      bus.res_src   <= 1'b0;
      bus.res_len   <= '0;
    end else begin
      bus.res_valid <= 1'b0;
      case (state)
        IDLE: begin
          len   <= '0;
          timer <= '0;
          if (bus.s0_valid || bus.s1_valid) begin
            owner <= (bus.s0_valid && bus.s1_valid) ? !last_grant : bus.s1_valid;
            state <= OWN;
          end
        end
        OWN: begin
          if (restart) begin
            bus.res_valid <= 1'b1;
            bus.res_ok    <= accept && (chk == DIGIT);
            bus.res_abort <= timeout_hit;
            bus.res_src   <= owner;
            bus.res_len   <= len;
            last_grant    <= owner;
            len           <= '0;
            timer         <= '0;
            state         <= IDLE;
          end else if (accept) begin
            timer <= '0;
            if (len != LEN_W'(MAX_LEN)) len <= len + 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
